// File: rtl/execute_mc.sv
// Multi-cycle Y86 execute stage: operand mux, ALU with iterative multiply,
// condition evaluation, condition-code register and registered output with handshakes.
module execute_mc #(
   parameter int DATA_W     = 64,
   parameter int MUL_STEP   = 1,
   parameter int STACK_STEP = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [3:0]        icode_i,
   input  logic [3:0]        ifun_i,
   input  logic [2:0]        stat_i,
   input  logic [3:0]        dstE_i,
   input  logic [DATA_W-1:0] valA_i,
   input  logic [DATA_W-1:0] valB_i,
   input  logic [DATA_W-1:0] valC_i,
   input  logic [2:0]        m_stat_i,
   input  logic [2:0]        W_stat_i,
   input  logic              flush_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] valE_o,
   output logic [3:0]        dstE_o,
   output logic              cnd_o,
   output logic [2:0]        stat_o,
   output logic [2:0]        cc_o,
   output logic              busy_o
);

   localparam int N  = DATA_W / MUL_STEP;
   localparam int CW = $clog2(N + 1);

   localparam logic [3:0] I_RRMOVQ = 4'h2, I_IRMOVQ = 4'h3, I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ = 4'h6, I_CALL = 4'h8, I_RET = 4'h9, I_PUSH = 4'hA, I_POP = 4'hB;
   localparam logic [3:0] F_ADD = 4'd0, F_SUB = 4'd1, F_AND = 4'd2, F_XOR = 4'd3, F_MUL = 4'd4;
   localparam logic [3:0] RNONE = 4'hF;
   localparam logic [2:0] SAOK = 3'd1, SINS = 3'd4;
   localparam logic [DATA_W-1:0] STK = DATA_W'(STACK_STEP);

   typedef enum logic {IDLE, MUL} state_t;
   state_t state, state_nx;

   logic [DATA_W-1:0] alu_a, alu_b, alu_res, res;
   logic [3:0]        alu_fun;
   logic [DATA_W-1:0] step_acc, step_cand, step_plier, plier_sh;
   logic [DATA_W-1:0] m_acc, m_cand, m_plier;
   logic [CW-1:0]     m_cnt;
   logic [3:0]        m_dst;
   logic [2:0]        m_stat;
   logic              m_cnd, m_cc_en;
   logic              zf, sf, of, of_flag, cnd, sins, cc_en;
   logic              accept, is_mul, mul_start, mul_done, load_now;
   logic [3:0]        dst_sel;
   logic [2:0]        stat_sel;

   assign in_ready_o = (state == IDLE) && (!out_valid_o || out_ready_i) && !flush_i;
   assign accept     = in_valid_i && in_ready_o;
   assign is_mul     = (icode_i == I_OPQ) && (ifun_i == F_MUL);
   assign mul_start  = accept && is_mul && (N > 1);
   assign mul_done   = (state == MUL) && (m_cnt == CW'(N - 1));
   assign load_now   = accept && !mul_start;
   assign busy_o     = (state == MUL);
   assign {zf, sf, of} = cc_o;

   always_comb begin
      alu_a   = '0;
      alu_b   = '0;
      alu_fun = F_ADD;
      case (icode_i)
         I_RRMOVQ:           alu_a = valA_i;
         I_IRMOVQ:           alu_a = valC_i;
         I_RMMOVQ, I_MRMOVQ: begin alu_a = valC_i; alu_b = valB_i; end
         I_OPQ:              begin alu_a = valA_i; alu_b = valB_i; alu_fun = ifun_i; end
         I_CALL, I_PUSH:     begin alu_a = -STK;   alu_b = valB_i; end
         I_RET, I_POP:       begin alu_a = STK;    alu_b = valB_i; end
         default: ;
      endcase
   end

   // One shift-add step; in IDLE it starts from the fresh operands so the
   // accept edge already retires the first MUL_STEP multiplier bits.
   always_comb begin
      step_acc   = (state == MUL) ? m_acc   : '0;
      step_cand  = (state == MUL) ? m_cand  : alu_a;
      step_plier = (state == MUL) ? m_plier : alu_b;
      plier_sh   = step_plier;
      for (int unsigned i = 0; i < MUL_STEP; i++) begin
         if (plier_sh[0]) step_acc = step_acc + (step_cand << i);
         plier_sh = plier_sh >> 1;
      end
   end

   always_comb begin
      alu_res = '0;
      of_flag = 1'b0;
      case (alu_fun)
         F_ADD: begin
            alu_res = alu_b + alu_a;
            of_flag = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) && (alu_res[DATA_W-1] != alu_a[DATA_W-1]);
         end
         F_SUB: begin
            alu_res = alu_b - alu_a;
            of_flag = (alu_a[DATA_W-1] != alu_b[DATA_W-1]) && (alu_res[DATA_W-1] != alu_b[DATA_W-1]);
         end
         F_AND:   alu_res = alu_b & alu_a;
         F_XOR:   alu_res = alu_b ^ alu_a;
         F_MUL:   alu_res = step_acc;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      case (ifun_i)
         4'd0:    cnd = 1'b1;
         4'd1:    cnd = (sf ^ of) | zf;
         4'd2:    cnd = sf ^ of;
         4'd3:    cnd = zf;
         4'd4:    cnd = !zf;
         4'd5:    cnd = !(sf ^ of);
         4'd6:    cnd = !(sf ^ of) && !zf;
         default: cnd = 1'b0;
      endcase
   end

   assign sins     = (icode_i == I_OPQ) && (ifun_i > F_MUL);
   assign cc_en    = (icode_i == I_OPQ) && (ifun_i <= F_MUL) && (m_stat_i == SAOK) && (W_stat_i == SAOK);
   assign res      = sins ? '0 : alu_res;
   assign stat_sel = sins ? SINS : stat_i;
   assign dst_sel  = ((icode_i == I_RRMOVQ) && !cnd) ? RNONE : dstE_i;

   always_comb begin
      state_nx = state;
      if (flush_i) state_nx = IDLE;
      else begin
         case (state)
            IDLE: if (mul_start) state_nx = MUL;
            MUL:  if (mul_done)  state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         out_valid_o <= 1'b0;
         valE_o      <= '0;
         dstE_o      <= RNONE;
         cnd_o       <= 1'b0;
         stat_o      <= '0;
         cc_o        <= 3'b100;
         m_acc       <= '0;
         m_cand      <= '0;
         m_plier     <= '0;
         m_cnt       <= '0;
         m_dst       <= RNONE;
         m_stat      <= '0;
         m_cnd       <= 1'b0;
         m_cc_en     <= 1'b0;
      end else begin
         state <= state_nx;
         // Flush takes priority over both a completing multiply and its CC write.
         if (flush_i) begin
            out_valid_o <= 1'b0;
         end else if (load_now) begin
            out_valid_o <= 1'b1;
            valE_o      <= res;
            dstE_o      <= dst_sel;
            cnd_o       <= cnd;
            stat_o      <= stat_sel;
            if (cc_en) cc_o <= {res == '0, res[DATA_W-1], of_flag && (alu_fun != F_MUL)};
         end else if (mul_done) begin
            out_valid_o <= 1'b1;
            valE_o      <= step_acc;
            dstE_o      <= m_dst;
            cnd_o       <= m_cnd;
            stat_o      <= m_stat;
            if (m_cc_en) cc_o <= {step_acc == '0, step_acc[DATA_W-1], 1'b0};
         end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
         end

         if (mul_start) begin
            m_acc   <= step_acc;
            m_cand  <= alu_a << MUL_STEP;
            m_plier <= alu_b >> MUL_STEP;
            m_cnt   <= CW'(1);
            m_dst   <= dstE_i;
            m_stat  <= stat_i;
            m_cnd   <= cnd;
            m_cc_en <= cc_en;
         end else if (state == MUL) begin
            m_acc   <= step_acc;
            m_cand  <= m_cand << MUL_STEP;
            m_plier <= m_plier >> MUL_STEP;
            m_cnt   <= m_cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_execute_mc.sv
// Bench for execute_mc: directed known-answer rows, randomized ops against a
// behavioural model, back-pressure, back-to-back, flush and reset-mid-multiply.
module tb_execute_mc;

   localparam int DW = 64;
   localparam int MS = 1;
   localparam int N  = DW / MS;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [3:0]    icode = '0, ifun = '0, dst_in = '0;
   logic [2:0]    stat_in = '0, m_stat = 3'd1, w_stat = 3'd1;
   logic [DW-1:0] val_a = '0, val_b = '0, val_c = '0;
   logic          flush = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] vale;
   logic [3:0]    dste;
   logic          cnd;
   logic [2:0]    stat_out, cc;
   logic          busy;

   always #5 clk = ~clk;

   execute_mc #(.DATA_W(DW), .MUL_STEP(MS), .STACK_STEP(8)) dut (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .icode_i(icode), .ifun_i(ifun), .stat_i(stat_in), .dstE_i(dst_in),
      .valA_i(val_a), .valB_i(val_b), .valC_i(val_c),
      .m_stat_i(m_stat), .W_stat_i(w_stat), .flush_i(flush),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .valE_o(vale), .dstE_o(dste), .cnd_o(cnd), .stat_o(stat_out),
      .cc_o(cc), .busy_o(busy)
   );

   int checks = 0;
   int errors = 0;

   logic [2:0]    mcc = 3'b100;
   logic [DW-1:0] e_vale;
   logic [3:0]    e_dst;
   logic          e_cnd;
   logic [2:0]    e_stat;
   int            e_lat;

   typedef struct {
      logic [3:0] ic, fn; logic [2:0] st; logic [3:0] de;
      logic [DW-1:0] va, vb, vc; logic [2:0] ms;
      logic [DW-1:0] xv; logic [3:0] xdst; logic xcnd; logic [2:0] xstat; logic [2:0] xcc; int xlat;
   } row_t;

   // Reference: Y86 execute semantics stated directly as arithmetic.
   task automatic model_exec(input logic [3:0] ic, fn, input logic [2:0] st, input logic [3:0] de,
                             input logic [DW-1:0] va, vb, vc, input logic [2:0] ms, ws);
      logic [DW-1:0] a, b, r;
      logic zf, sf, ovf;
      zf = mcc[2]; sf = mcc[1]; ovf = mcc[0];
      case (fn)
         4'd0: e_cnd = 1'b1;
         4'd1: e_cnd = (sf != ovf) || zf;
         4'd2: e_cnd = (sf != ovf);
         4'd3: e_cnd = zf;
         4'd4: e_cnd = !zf;
         4'd5: e_cnd = (sf == ovf);
         4'd6: e_cnd = (sf == ovf) && !zf;
         default: e_cnd = 1'b0;
      endcase
      a = '0; b = '0;
      case (ic)
         4'h2: a = va;
         4'h3: a = vc;
         4'h4, 4'h5: begin a = vc; b = vb; end
         4'h6: begin a = va; b = vb; end
         4'h8, 4'hA: begin a = -64'd8; b = vb; end
         4'h9, 4'hB: begin a = 64'd8; b = vb; end
         default: ;
      endcase
      r = b + a;
      if (ic == 4'h6) begin
         case (fn)
            4'd0: r = b + a;
            4'd1: r = b - a;
            4'd2: r = b & a;
            4'd3: r = b ^ a;
            4'd4: r = b * a;
            default: r = '0;
         endcase
      end
      e_vale = r;
      e_stat = (ic == 4'h6 && fn > 4) ? 3'd4 : st;
      e_dst  = (ic == 4'h2 && !e_cnd) ? 4'hF : de;
      e_lat  = (ic == 4'h6 && fn == 4) ? N : 1;
      if (ic == 4'h6 && fn <= 4 && ms == 3'd1 && ws == 3'd1) begin
         ovf = 1'b0;
         if (fn == 0) ovf = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]);
         if (fn == 1) ovf = (a[DW-1] != b[DW-1]) && (r[DW-1] != b[DW-1]);
         mcc = {r == 0, r[DW-1], ovf};
      end
   endtask

   task automatic drive(input logic [3:0] ic, fn, input logic [2:0] st, input logic [3:0] de,
                        input logic [DW-1:0] va, vb, vc, input logic [2:0] ms, ws);
      icode = ic; ifun = fn; stat_in = st; dst_in = de;
      val_a = va; val_b = vb; val_c = vc; m_stat = ms; w_stat = ws;
      in_valid = 1'b1;
   endtask

   task automatic wait_accept(output bit ok, output int waited);
      waited = 0;
      #1;
      while (!in_ready && waited < 300) begin @(negedge clk); #1; waited++; end
      ok = in_ready;
      if (ok) begin @(posedge clk); #1; end
      in_valid = 1'b0;
   endtask

   task automatic wait_result(output int lat, output int busy_n);
      lat = 0; busy_n = 0;
      do begin
         @(negedge clk);
         lat++;
         if (busy) busy_n++;
      end while (!out_valid && lat < 300);
      if (!out_valid) lat = -1;
   endtask

   function automatic logic [DW-1:0] rand_val();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return 64'd1;
         2: return 64'h7FFF_FFFF_FFFF_FFFF;
         3: return 64'h8000_0000_0000_0000;
         4: return 64'(($urandom_range(0, 20)));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   task automatic rand_op(input bit allow_mul, output logic [3:0] ic, fn, output logic [2:0] st,
                          output logic [3:0] de, output logic [DW-1:0] va, vb, vc, output logic [2:0] ms, ws);
      ic = 4'($urandom_range(0, 15));
      fn = 4'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) ic = 4'h6;
      if (allow_mul && $urandom_range(0, 5) == 0) begin ic = 4'h6; fn = 4'd4; end
      if (!allow_mul && ic == 4'h6 && fn == 4'd4) fn = 4'd1;
      st = 3'($urandom_range(1, 4));
      de = 4'($urandom_range(0, 15));
      va = rand_val(); vb = rand_val(); vc = rand_val();
      ms = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      ws = ($urandom_range(0, 5) == 0) ? 3'd2 : 3'd1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
      checks++; if (vale !== '0) begin errors++; $display("FAIL reset_vale got %h want 0", vale); end
      checks++; if (dste !== 4'hF) begin errors++; $display("FAIL reset_dst got %h want f", dste); end
      checks++; if ({cnd, stat_out} !== 4'b0) begin errors++; $display("FAIL reset_cnd_stat got %b%b want 0", cnd, stat_out); end
      checks++; if (cc !== 3'b100) begin errors++; $display("FAIL reset_cc got %b want 100", cc); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
      mcc = 3'b100;
   endtask

   task automatic test_directed();
      row_t t[13];
      bit ok; int w, lat, bn;
      t[0]  = '{4'h6, 4'd0, 3'd1, 4'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 3'd1, 64'h8000_0000_0000_0000, 4'd2, 1'b1, 3'd1, 3'b011, 1};
      t[1]  = '{4'h6, 4'd1, 3'd1, 4'd2, 64'd5, 64'd5, 64'd0, 3'd1, 64'd0, 4'd2, 1'b0, 3'd1, 3'b100, 1};
      t[2]  = '{4'h2, 4'd1, 3'd1, 4'd3, 64'h1234, 64'd0, 64'd0, 3'd1, 64'h1234, 4'd3, 1'b1, 3'd1, 3'b100, 1};
      t[3]  = '{4'h6, 4'd4, 3'd1, 4'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 3'd1, 64'hFFFF_FFFF_FFFF_FFEB, 4'd5, 1'b0, 3'd1, 3'b010, N};
      t[4]  = '{4'h6, 4'd0, 3'd1, 4'd6, 64'd1, 64'd2, 64'd0, 3'd3, 64'd3, 4'd6, 1'b1, 3'd1, 3'b010, 1};
      t[5]  = '{4'h6, 4'd1, 3'd1, 4'd6, 64'd4, 64'd4, 64'd0, 3'd1, 64'd0, 4'd6, 1'b1, 3'd1, 3'b100, 1};
      t[6]  = '{4'h2, 4'd4, 3'd1, 4'd7, 64'd9, 64'd0, 64'd0, 3'd1, 64'd9, 4'hF, 1'b0, 3'd1, 3'b100, 1};
      t[7]  = '{4'h6, 4'd6, 3'd1, 4'd8, 64'd3, 64'd4, 64'd0, 3'd1, 64'd0, 4'd8, 1'b0, 3'd4, 3'b100, 1};
      t[8]  = '{4'h8, 4'd0, 3'd1, 4'd4, 64'd0, 64'h100, 64'd0, 3'd1, 64'hF8, 4'd4, 1'b1, 3'd1, 3'b100, 1};
      t[9]  = '{4'hB, 4'd0, 3'd1, 4'd4, 64'd0, 64'h100, 64'd0, 3'd1, 64'h108, 4'd4, 1'b1, 3'd1, 3'b100, 1};
      t[10] = '{4'h0, 4'd0, 3'd2, 4'hF, 64'd5, 64'd6, 64'd7, 3'd1, 64'd0, 4'hF, 1'b1, 3'd2, 3'b100, 1};
      t[11] = '{4'h3, 4'd2, 3'd1, 4'd9, 64'd0, 64'd0, 64'hABC, 3'd1, 64'hABC, 4'd9, 1'b0, 3'd1, 3'b100, 1};
      t[12] = '{4'h5, 4'd3, 3'd1, 4'd1, 64'd0, 64'h10, 64'h20, 3'd1, 64'h30, 4'd1, 1'b1, 3'd1, 3'b100, 1};
      foreach (t[i]) begin
         @(negedge clk);
         drive(t[i].ic, t[i].fn, t[i].st, t[i].de, t[i].va, t[i].vb, t[i].vc, t[i].ms, 3'd1);
         wait_accept(ok, w);
         checks++; if (!ok) begin errors++; $display("FAIL dir%0d_accept got in_ready=%b want 1", i, in_ready); end
         model_exec(t[i].ic, t[i].fn, t[i].st, t[i].de, t[i].va, t[i].vb, t[i].vc, t[i].ms, 3'd1);
         wait_result(lat, bn);
         checks++; if (lat !== t[i].xlat) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, t[i].xlat); end
         checks++; if (bn !== t[i].xlat - 1) begin errors++; $display("FAIL dir%0d_busy_cycles got %0d want %0d", i, bn, t[i].xlat - 1); end
         checks++; if (vale !== t[i].xv) begin errors++; $display("FAIL dir%0d_vale got %h want %h", i, vale, t[i].xv); end
         checks++; if (dste !== t[i].xdst) begin errors++; $display("FAIL dir%0d_dst got %h want %h", i, dste, t[i].xdst); end
         checks++; if (cnd !== t[i].xcnd) begin errors++; $display("FAIL dir%0d_cnd got %b want %b", i, cnd, t[i].xcnd); end
         checks++; if (stat_out !== t[i].xstat) begin errors++; $display("FAIL dir%0d_stat got %0d want %0d", i, stat_out, t[i].xstat); end
         checks++; if (cc !== t[i].xcc) begin errors++; $display("FAIL dir%0d_cc got %b want %b", i, cc, t[i].xcc); end
      end
   endtask

   task automatic test_random();
      logic [3:0] ic, fn, de; logic [2:0] st, ms, ws; logic [DW-1:0] va, vb, vc;
      bit ok; int w, lat, bn;
      for (int k = 0; k < 30; k++) begin
         rand_op(1'b1, ic, fn, st, de, va, vb, vc, ms, ws);
         @(negedge clk);
         drive(ic, fn, st, de, va, vb, vc, ms, ws);
         wait_accept(ok, w);
         checks++; if (!ok) begin errors++; $display("FAIL rnd%0d_accept got in_ready=%b want 1", k, in_ready); end
         model_exec(ic, fn, st, de, va, vb, vc, ms, ws);
         wait_result(lat, bn);
         checks++; if (lat !== e_lat) begin errors++; $display("FAIL rnd%0d_latency got %0d want %0d", k, lat, e_lat); end
         checks++; if (vale !== e_vale) begin errors++; $display("FAIL rnd%0d_vale ic=%h fn=%h got %h want %h", k, ic, fn, vale, e_vale); end
         checks++; if (dste !== e_dst) begin errors++; $display("FAIL rnd%0d_dst got %h want %h", k, dste, e_dst); end
         checks++; if (cnd !== e_cnd) begin errors++; $display("FAIL rnd%0d_cnd got %b want %b", k, cnd, e_cnd); end
         checks++; if (stat_out !== e_stat) begin errors++; $display("FAIL rnd%0d_stat got %0d want %0d", k, stat_out, e_stat); end
         checks++; if (cc !== mcc) begin errors++; $display("FAIL rnd%0d_cc got %b want %b", k, cc, mcc); end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] ic, fn, de; logic [2:0] st, ms, ws; logic [DW-1:0] va, vb, vc;
      logic [DW-1:0] p_vale; logic [3:0] p_dst; logic p_cnd; logic [2:0] p_stat;
      out_ready = 1'b1;
      for (int k = 0; k <= 20; k++) begin
         @(negedge clk);
         if (k > 0) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b%0d_valid got %b want 1", k, out_valid); end
            checks++; if (vale !== p_vale) begin errors++; $display("FAIL b2b%0d_vale got %h want %h", k, vale, p_vale); end
            checks++; if ({dste, cnd, stat_out} !== {p_dst, p_cnd, p_stat}) begin
               errors++; $display("FAIL b2b%0d_dst_cnd_stat got %h/%b/%0d want %h/%b/%0d", k, dste, cnd, stat_out, p_dst, p_cnd, p_stat);
            end
            checks++; if (cc !== mcc) begin errors++; $display("FAIL b2b%0d_cc got %b want %b", k, cc, mcc); end
         end
         if (k == 20) begin in_valid = 1'b0; break; end
         rand_op(1'b0, ic, fn, st, de, va, vb, vc, ms, ws);
         drive(ic, fn, st, de, va, vb, vc, ms, ws);
         #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b%0d_ready got %b want 1", k, in_ready); end
         model_exec(ic, fn, st, de, va, vb, vc, ms, ws);
         p_vale = e_vale; p_dst = e_dst; p_cnd = e_cnd; p_stat = e_stat;
      end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] first_v;
      bit ok; int w, lat, bn;
      @(negedge clk);
      out_ready = 1'b0;
      drive(4'h6, 4'd0, 3'd1, 4'd3, 64'd40, 64'd2, 64'd0, 3'd1, 3'd1);
      wait_accept(ok, w);
      model_exec(4'h6, 4'd0, 3'd1, 4'd3, 64'd40, 64'd2, 64'd0, 3'd1, 3'd1);
      first_v = e_vale;
      @(negedge clk);
      checks++; if (!ok || out_valid !== 1'b1 || vale !== first_v) begin
         errors++; $display("FAIL bp_first got valid=%b vale=%h want 1/%h", out_valid, vale, first_v);
      end
      drive(4'h6, 4'd3, 3'd1, 4'd4, 64'hF0, 64'hFF, 64'd0, 3'd1, 3'd1);
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold%0d_ready got %b want 0", i, in_ready); end
         checks++; if (out_valid !== 1'b1 || vale !== first_v) begin
            errors++; $display("FAIL bp_hold%0d_vale got %b/%h want 1/%h", i, out_valid, vale, first_v);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      wait_accept(ok, w);
      checks++; if (!ok || w !== 0) begin errors++; $display("FAIL bp_release_accept got ok=%b wait=%0d want 1/0", ok, w); end
      model_exec(4'h6, 4'd3, 3'd1, 4'd4, 64'hF0, 64'hFF, 64'd0, 3'd1, 3'd1);
      wait_result(lat, bn);
      checks++; if (lat !== 1 || vale !== e_vale) begin
         errors++; $display("FAIL bp_second got lat=%0d vale=%h want 1/%h", lat, vale, e_vale);
      end
   endtask

   task automatic test_flush();
      bit ok; int w, stray;
      @(negedge clk);
      drive(4'h6, 4'd4, 3'd1, 4'd2, 64'd0, 64'd5, 64'd0, 3'd1, 3'd1);
      wait_accept(ok, w);
      repeat (10) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_before got %b want 1", busy); end
      flush = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready_during got %b want 0", in_ready); end
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_abort got valid=%b busy=%b want 0/0", out_valid, busy); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_after got %b want 1", in_ready); end
      checks++; if (cc !== mcc) begin errors++; $display("FAIL flush_cc got %b want %b", cc, mcc); end
      stray = 0;
      repeat (N + 8) begin @(negedge clk); if (out_valid) stray++; end
      checks++; if (stray !== 0 || cc !== mcc) begin errors++; $display("FAIL flush_no_result got %0d/%b want 0/%b", stray, cc, mcc); end
   endtask

   task automatic test_reset_mid_mul();
      bit ok; int w, stray;
      @(negedge clk);
      drive(4'h6, 4'd4, 3'd1, 4'd2, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 3'd1, 3'd1);
      wait_accept(ok, w);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      mcc = 3'b100;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || cc !== 3'b100) begin
         errors++; $display("FAIL rstmul_state got busy=%b valid=%b cc=%b want 0/0/100", busy, out_valid, cc);
      end
      stray = 0;
      repeat (N + 8) begin @(negedge clk); if (out_valid) stray++; end
      checks++; if (stray !== 0 || cc !== 3'b100) begin errors++; $display("FAIL rstmul_no_result got %0d/%b want 0/100", stray, cc); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_reset_mid_mul();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/execute_mc.md
Name: execute_mc

Overview:
- Parametrised, multi-cycle successor to the single-cycle Y86 execute stage. Computes valE, the condition flag and the final dstE. Holds the condition-code register.
- Adds a width parameter, an iterative OPQ multiply (ifun 4) and valid/ready handshakes on both sides. Adds a flush input and registered outputs.
- Sits between the decode pipeline register and the memory stage.

Parameters:
- DATA_W, 64, operand/result width. Must be ≥8.
- MUL_STEP, 1, multiplier bits retired per busy cycle. Must divide DATA_W.
- STACK_STEP, 8, stack-pointer adjust for call/push/ret/pop.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  decode offers an instruction.
- in_ready_o  out  1  stage can accept this cycle.
- icode_i  in  4  instruction code.
- ifun_i  in  4  function / condition code.
- stat_i  in  3  instruction status.
- dstE_i  in  4  destination register for E.
- valA_i, valB_i, valC_i  in  DATA_W each  operands.
- m_stat_i, W_stat_i  in  3 each  downstream status, sampled at accept.
- flush_i  in  1  discard in-flight instruction.
- out_valid_o  out  1  result register valid.
- out_ready_i  in  1  memory stage takes result.
- valE_o  out  DATA_W  result.
- dstE_o  out  4  final dstE (RNONE=4'hF when cmov not taken).
- cnd_o  out  1  condition outcome.
- stat_o  out  3  status passthrough.
- cc_o  out  3  {ZF,SF,OF}.
- busy_o  out  1  multiplier active.

Behaviour:
- Reset (rst_i high at edge):
  - state=IDLE.
  - out_valid_o=0, valE_o=0, dstE_o=4'hF, cnd_o=0, stat_o=0.
  - cc_o=3'b100, busy_o=0.
- Handshake:
  - in_ready_o = (state==IDLE) && (!out_valid_o || out_ready_i) && !flush_i.
  - Accept = in_valid_i && in_ready_o.
  - Output register holds unchanged while out_valid_o && !out_ready_i.
  - out_valid_o drops after a taken result unless a new result loads on the same edge.
- Operand mux: aluA/aluB/alu_fun per Y86:
  - rrmovq: A=valA, B=0.
  - irmovq: A=valC, B=0.
  - rmmovq/mrmovq: A=valC, B=valB.
  - OPQ: A=valA, B=valB, fun=ifun.
  - call/push: A=-STACK_STEP, B=valB.
  - ret/pop: A=+STACK_STEP, B=valB.
  - All other icodes: A=B=0, fun=ADD.
- ALU functions, modulo 2^DATA_W:
  - 0 ADD: B+A.
  - 1 SUB: B−A.
  - 2 AND.
  - 3 XOR.
  - 4 MUL: low DATA_W bits of B×A; identical for signed and unsigned.
  - ifun>4 with OPQ: stat_o=SINS (3'd4), valE_o=0, no CC update.
- Condition evaluation:
  - cnd uses cc_o as it stands at the accept edge.
  - Encoding: 0 YES, 1 LE, 2 L, 3 E, 4 NE, 5 GE, 6 G; others false.
  - cnd_o is registered.
  - dstE_o = (icode==rrmovq && !cnd) ? 4'hF : dstE_i.
- Non-MUL latency: 1. Output register loads on the accept edge; out_valid_o is high the next cycle.
- MUL path:
  - FSM IDLE→MUL on accept of OPQ/ifun 4. Operands, stat, dstE and CC-enable are latched on that edge.
  - N=DATA_W/MUL_STEP edges total, counting the accept edge as step 1. Each step adds MUL_STEP partial products, shift-add.
  - On the Nth edge the output register loads and the FSM returns to IDLE.
  - busy_o = (state==MUL).
  - With MUL_STEP=DATA_W the behaviour is identical to the 1-cycle path.
  - Entry to MUL requires in_ready_o, so the output register is free when the multiply completes.
- CC update:
  - Applies only to OPQ with ifun 0–4, and only when m_stat_i==SAOK(1) && W_stat_i==SAOK at accept.
  - Written on the edge the result loads.
  - ZF = (res==0). SF = res[DATA_W-1].
  - OF for ADD: A,B same sign and res sign differs.
  - OF for SUB: A,B differ in sign and res sign ≠ B sign.
  - OF = 0 for AND, XOR and MUL.
- Flush:
  - flush_i high at an edge clears out_valid_o and aborts MUL (state→IDLE).
  - It suppresses any pending CC write. No accept occurs that cycle.
  - Flush and reset together: reset wins.
- HALT (icode 0): no simulation stop. Passes through with its stat_i and valE=0.
- Reset mid-MUL: abandons the multiply; no CC write.

Test Plan:
- Reset, then addq A=0x7FFF_FFFF_FFFF_FFFF, B=1, stats AOK → valE=0x8000_0000_0000_0000 next cycle; cc_o=3'b011.
- subq A=5, B=5 → valE=0, cc_o=3'b100. Then cmovle with dstE=3 → cnd_o=1, dstE_o=3.
- mulq A=7, B=−3 (MUL_STEP=1) → in_ready_o low 63 cycles; out_valid_o high exactly 64 cycles after accept; valE=−21; cc_o=3'b010.
- Repeat with MUL_STEP=8 → 8-cycle latency, same result. MUL_STEP=64 → 1-cycle latency.
- Hold out_ready_i=0 for 5 cycles after an ALU result → valE_o stable; in_ready_o=0; next instruction accepted the cycle out_ready_i=1.
- Pulse flush_i in cycle 10 of a mul → out_valid_o stays 0; cc_o unchanged; in_ready_o=1 next cycle.
- addq with m_stat_i=SADR → valE correct; cc_o unchanged. cmovne after ZF=1 → dstE_o=4'hF.
